// File: rtl/square_sweep_channel.sv
// square_sweep_channel: square-wave voice with a duty sequencer, length
// counter, volume envelope and an optional frequency sweep unit.
// Optional feature: define SQUARE_SWEEP_CHANNEL_SWEEP_EN to build the sweep unit;
// without it register 0 and sweep_tick are ignored.
module square_sweep_channel #(
  parameter int unsigned FREQ_W = 11,
  parameter int unsigned LEN_W  = 6
) (
  input  logic       dova_phi,
  input  logic       apu_reset,
  input  logic       timer_tick,
  input  logic       len_tick,
  input  logic       sweep_tick,
  input  logic       env_tick,
  input  logic       apu_wr,
  input  logic [2:0] addr,
  input  logic [7:0] d,
  output logic [3:0] ch_out,
  output logic       ch_active,
  output logic       dac_en
);

  localparam logic [FREQ_W-1:0] TIMER_STEP = FREQ_W'(1);
  localparam logic [LEN_W-1:0]  LEN_STEP   = LEN_W'(1);

  logic [FREQ_W-1:0] freq;
  logic [FREQ_W-1:0] timer;
  logic [FREQ_W-1:0] freq_wr;
  logic [2:0]        duty_step;
  logic [1:0]        duty_sel;
  logic [7:0]        duty_pat;
  logic              duty_bit;
  logic [LEN_W-1:0]  len_cnt;
  logic [LEN_W-1:0]  len_inc;
  logic              len_en;
  logic              len_expire;
  logic [3:0]        init_vol;
  logic [3:0]        volume;
  logic              env_dir;
  logic [2:0]        env_period;
  logic [2:0]        env_div;
  logic              wr1, wr2, wr3, wr4;
  logic              trigger;
  logic              dac_drop;
  logic              sweep_ovf;
  logic              trig_ovf;
  logic              sweep_upd;
  logic [FREQ_W-1:0] sweep_freq;

  assign wr1     = apu_wr && (addr == 3'd1);
  assign wr2     = apu_wr && (addr == 3'd2);
  assign wr3     = apu_wr && (addr == 3'd3);
  assign wr4     = apu_wr && (addr == 3'd4);
  assign trigger = wr4 && d[7];

  assign dac_en     = (init_vol != 4'd0) || env_dir;
  assign dac_drop   = wr2 && (d[7:3] == 5'd0);
  assign len_inc    = len_cnt + LEN_STEP;
  assign len_expire = len_tick && len_en && !wr1 && (len_cnt != '1) && (len_inc == '1);

  // Frequency as it will read after this cycle's register 3/4 write
  always_comb begin
    freq_wr = freq;
    if (wr3) freq_wr[7:0] = d;
    if (wr4) freq_wr[FREQ_W-1:8] = d[FREQ_W-9:0];
  end

  // Duty pattern lookup; bit index is the duty step
  always_comb begin
    case (duty_sel)
      2'd0:    duty_pat = 8'b1000_0000;
      2'd1:    duty_pat = 8'b1000_0001;
      2'd2:    duty_pat = 8'b1110_0001;
      default: duty_pat = 8'b0111_1110;
    endcase
  end
  assign duty_bit = duty_pat[duty_step];

`ifdef SQUARE_SWEEP_CHANNEL_SWEEP_EN
  logic              wr0;
  logic [2:0]        sweep_period;
  logic              sweep_negate;
  logic [2:0]        sweep_shift;
  logic [2:0]        sweep_div;
  logic [FREQ_W-1:0] shadow;
  logic [FREQ_W:0]   sweep_new;
  logic [FREQ_W:0]   trig_new;
  logic              sweep_fire;

  // Extra top bit flags a target beyond the frequency range
  function automatic logic [FREQ_W:0] sweep_target(input logic [FREQ_W-1:0] base,
                                                    input logic neg,
                                                    input logic [2:0] sh);
    logic [FREQ_W:0] delta;
    delta = {1'b0, base >> sh};
    return neg ? ({1'b0, base} - delta) : ({1'b0, base} + delta);
  endfunction

  assign wr0        = apu_wr && (addr == 3'd0);
  assign sweep_new  = sweep_target(shadow, sweep_negate, sweep_shift);
  assign trig_new   = sweep_target(freq_wr, sweep_negate, sweep_shift);
  assign sweep_fire = sweep_tick && (sweep_period != 3'd0) && (sweep_div <= 3'd1);
  assign sweep_ovf  = sweep_fire && sweep_new[FREQ_W];
  assign trig_ovf   = (sweep_shift != 3'd0) && trig_new[FREQ_W];
  assign sweep_upd  = sweep_fire && !sweep_new[FREQ_W] && (sweep_shift != 3'd0);
  assign sweep_freq = sweep_new[FREQ_W-1:0];

  // Sweep configuration, divider and shadow frequency
  always_ff @(posedge dova_phi) begin
    if (apu_reset) begin
      sweep_period <= '0;
      sweep_negate <= 1'b0;
      sweep_shift  <= '0;
      sweep_div    <= '0;
      shadow       <= '0;
    end else if (trigger) begin
      sweep_div <= sweep_period;
      shadow    <= freq_wr;
    end else begin
      if (wr0) begin
        sweep_period <= d[6:4];
        sweep_negate <= d[3];
        sweep_shift  <= d[2:0];
      end
      if (sweep_tick && (sweep_period != 3'd0)) begin
        if (sweep_div <= 3'd1) begin
          sweep_div <= sweep_period;
          if (sweep_upd) shadow <= sweep_freq;
        end else begin
          sweep_div <= sweep_div - 3'd1;
        end
      end
    end
  end
`else
  logic unused_sweep_tick;
  assign unused_sweep_tick = sweep_tick;
  assign sweep_ovf  = 1'b0;
  assign trig_ovf   = 1'b0;
  assign sweep_upd  = 1'b0;
  assign sweep_freq = '0;
`endif

  // Channel state: trigger overrides every tick; later writes override ticks
  always_ff @(posedge dova_phi) begin
    if (apu_reset) begin
      freq       <= '0;
      timer      <= '0;
      duty_step  <= '0;
      duty_sel   <= '0;
      len_cnt    <= '0;
      len_en     <= 1'b0;
      init_vol   <= '0;
      env_dir    <= 1'b0;
      env_period <= '0;
      env_div    <= '0;
      volume     <= '0;
      ch_active  <= 1'b0;
    end else if (trigger) begin
      ch_active <= dac_en && !trig_ovf;
      freq      <= freq_wr;
      timer     <= freq_wr;
      duty_step <= '0;
      volume    <= init_vol;
      env_div   <= env_period;
      len_en    <= d[6];
    end else begin
      if (timer_tick) begin
        if (timer == '1) begin
          timer     <= freq;
          duty_step <= duty_step + 3'd1;
        end else begin
          timer <= timer + TIMER_STEP;
        end
      end
      if (len_tick && len_en && !wr1 && (len_cnt != '1)) len_cnt <= len_inc;
      if (env_tick && (env_period != 3'd0)) begin
        if (env_div <= 3'd1) begin
          env_div <= env_period;
          if (env_dir && (volume != 4'hF))       volume <= volume + 4'd1;
          else if (!env_dir && (volume != 4'h0)) volume <= volume - 4'd1;
        end else begin
          env_div <= env_div - 3'd1;
        end
      end
      if (sweep_upd) freq <= sweep_freq;
      if (wr1) begin
        duty_sel <= d[7:6];
        len_cnt  <= d[LEN_W-1:0];
      end
      if (wr2) begin
        init_vol   <= d[7:4];
        env_dir    <= d[3];
        env_period <= d[2:0];
      end
      if (wr3 || wr4) freq <= freq_wr;
      if (wr4) len_en <= d[6];
      if (len_expire || sweep_ovf || dac_drop) ch_active <= 1'b0;
    end
  end

  // Registered sample output
  always_ff @(posedge dova_phi) begin
    if (apu_reset) ch_out <= '0;
    else           ch_out <= (ch_active && duty_bit) ? volume : 4'd0;
  end

endmodule

// File: tb/tb_square_sweep_channel.sv
// tb_square_sweep_channel: directed scenarios plus randomized traffic checked
// against a behavioural model of the channel kept in plain integers.
module tb_square_sweep_channel;

  localparam int FREQ_W = 11;
  localparam int LEN_W  = 6;
  localparam int FMAX   = (1 << FREQ_W) - 1;
  localparam int LMAX   = (1 << LEN_W) - 1;

  logic       dova_phi = 1'b0;
  logic       apu_reset, timer_tick, len_tick, sweep_tick, env_tick, apu_wr;
  logic [2:0] addr;
  logic [7:0] d;
  logic [3:0] ch_out;
  logic       ch_active, dac_en;

  int n_vec = 0;
  int n_bad = 0;

  string duty_pat [4] = '{"00000001", "10000001", "10000111", "01111110"};

  // Model state
  int m_freq, m_timer, m_step, m_duty, m_len, m_len_en;
  int m_init_vol, m_dir, m_env_per, m_env_cnt, m_vol;
  int m_sw_per, m_neg, m_shift, m_sw_cnt, m_shadow, m_active;
  int exp_out;

  always #5 dova_phi = ~dova_phi;

  square_sweep_channel #(.FREQ_W(FREQ_W), .LEN_W(LEN_W)) dut (
    .dova_phi  (dova_phi),
    .apu_reset (apu_reset),
    .timer_tick(timer_tick),
    .len_tick  (len_tick),
    .sweep_tick(sweep_tick),
    .env_tick  (env_tick),
    .apu_wr    (apu_wr),
    .addr      (addr),
    .d         (d),
    .ch_out    (ch_out),
    .ch_active (ch_active),
    .dac_en    (dac_en)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int target(input int base, input int neg, input int sh);
    int delta;
    delta = base / (1 << sh);
    return (neg != 0) ? base - delta : base + delta;
  endfunction

  function automatic int model_dac();
    return (m_init_vol != 0 || m_dir != 0) ? 1 : 0;
  endfunction

  task automatic model_edge(input bit rst, input bit wr, input int a, input int dd,
                            input bit tt, input bit lt, input bit st, input bit et);
    int fnew, t;
    bit trig;
    if (rst) begin
      exp_out = 0;
      m_freq = 0; m_timer = 0; m_step = 0; m_duty = 0; m_len = 0; m_len_en = 0;
      m_init_vol = 0; m_dir = 0; m_env_per = 0; m_env_cnt = 0; m_vol = 0;
      m_sw_per = 0; m_neg = 0; m_shift = 0; m_sw_cnt = 0; m_shadow = 0; m_active = 0;
      return;
    end
    exp_out = (m_active != 0 && duty_pat[m_duty].getc(m_step) == 8'h31) ? m_vol : 0;
    trig = wr && a == 4 && dd[7];
    fnew = m_freq;
    if (wr && a == 3) fnew = (fnew / 256) * 256 + dd;
    if (wr && a == 4) fnew = (fnew % 256) + (dd % (1 << (FREQ_W - 8))) * 256;
    if (trig) begin
      m_active = model_dac();
`ifdef SQUARE_SWEEP_CHANNEL_SWEEP_EN
      if (m_shift != 0 && target(fnew, m_neg, m_shift) > FMAX) m_active = 0;
`endif
      m_freq = fnew; m_timer = fnew; m_step = 0; m_vol = m_init_vol;
      m_env_cnt = m_env_per; m_sw_cnt = m_sw_per; m_shadow = fnew;
      m_len_en = dd[6];
      return;
    end
    if (tt) begin
      if (m_timer == FMAX) begin
        m_timer = m_freq;
        m_step = (m_step + 1) % 8;
      end else m_timer++;
    end
    if (lt && m_len_en != 0 && !(wr && a == 1) && m_len != LMAX) begin
      m_len++;
      if (m_len == LMAX) m_active = 0;
    end
    if (et && m_env_per != 0) begin
      if (m_env_cnt <= 1) begin
        m_env_cnt = m_env_per;
        if (m_dir != 0) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
        else            m_vol = (m_vol > 0) ? m_vol - 1 : 0;
      end else m_env_cnt--;
    end
`ifdef SQUARE_SWEEP_CHANNEL_SWEEP_EN
    if (st && m_sw_per != 0) begin
      if (m_sw_cnt <= 1) begin
        m_sw_cnt = m_sw_per;
        t = target(m_shadow, m_neg, m_shift);
        if (t > FMAX) m_active = 0;
        else if (m_shift != 0) begin
          m_shadow = t;
          m_freq = t;
        end
      end else m_sw_cnt--;
    end
    if (wr && a == 0) begin
      m_sw_per = (dd / 16) % 8; m_neg = dd[3]; m_shift = dd % 8;
    end
`endif
    if (wr && a == 1) begin
      m_duty = dd / 64;
      m_len = dd % (LMAX + 1);
    end
    if (wr && a == 2) begin
      m_init_vol = dd / 16; m_dir = dd[3]; m_env_per = dd % 8;
      if (model_dac() == 0) m_active = 0;
    end
    if (wr && (a == 3 || a == 4)) m_freq = fnew;
    if (wr && a == 4) m_len_en = dd[6];
  endtask

  task automatic cycle(input bit rst, input bit wr, input int a, input int dd,
                       input bit tt, input bit lt, input bit st, input bit et);
    apu_reset = rst; apu_wr = wr; addr = a[2:0]; d = dd[7:0];
    timer_tick = tt; len_tick = lt; sweep_tick = st; env_tick = et;
    model_edge(rst, wr, a, dd, tt, lt, st, et);
    @(posedge dova_phi);
    @(negedge dova_phi);
    check("ch_out", int'(ch_out), exp_out);
    check("ch_active", int'(ch_active), m_active);
    check("dac_en", int'(dac_en), model_dac());
  endtask

  task automatic wr_reg(input int a, input int dd);
    cycle(1'b0, 1'b1, a, dd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int seq [8] = '{15, 0, 0, 0, 0, 15, 15, 15};
  int ev  [4] = '{2, 1, 0, 0};

  initial begin
    // Power-up reset
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("init_out", int'(ch_out), 0);
    check("init_act", int'(ch_active), 0);

    // Reset aborts an active channel
    wr_reg(2, 8'hF0);
    wr_reg(4, 8'h87);
    check("pre_rst_act", int'(ch_active), 1);
    cycle(1'b1, 1'b1, 2, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_out", int'(ch_out), 0);
    check("rst_act", int'(ch_active), 0);
    check("rst_dac", int'(dac_en), 0);

    // Duty 2 at freq 0x7FC: four ticks per step
    wr_reg(1, 8'h80);
    wr_reg(2, 8'hF0);
    wr_reg(3, 8'hFC);
    wr_reg(4, 8'h87);
    for (int j = 1; j <= 32; j++) begin
      cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("duty_seq", int'(ch_out), seq[(j - 1) / 4]);
    end

    // Length expiry
    wr_reg(1, 8'h3E);
    wr_reg(4, 8'hC0);
    check("len_act_pre", int'(ch_active), 1);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check("len_act", int'(ch_active), 0);
    check("len_out", int'(ch_out), 0);

    // Envelope decay from 3 with period 1
    wr_reg(1, 8'h40);
    wr_reg(2, 8'h31);
    wr_reg(4, 8'h80);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      check("env_vol", int'(ch_out), ev[i]);
    end

    // Sweep overflow at 0x700 + 0x380
    wr_reg(0, 8'h11);
    wr_reg(3, 8'h00);
    wr_reg(4, 8'h87);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
`ifdef SQUARE_SWEEP_CHANNEL_SWEEP_EN
    check("sweep_act", int'(ch_active), 0);
`else
    check("sweep_act", int'(ch_active), 1);
`endif

    // Collisions: trigger discards ticks; reg1 write beats len_tick; reg2 drop
    wr_reg(0, 8'h00);
    wr_reg(2, 8'hF0);
    wr_reg(1, 8'h3D);
    cycle(1'b0, 1'b1, 4, 8'hC0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("coll_trig_len1", int'(ch_active), 1);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("coll_trig_len2", int'(ch_active), 0);
    wr_reg(4, 8'hC0);
    cycle(1'b0, 1'b1, 1, 8'h3E, 1'b0, 1'b1, 1'b0, 1'b0);
    check("coll_wr1_len", int'(ch_active), 1);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("coll_wr1_after", int'(ch_active), 0);
    wr_reg(4, 8'h80);
    check("coll_retrig", int'(ch_active), 1);
    wr_reg(2, 8'h00);
    check("coll_dac_act", int'(ch_active), 0);
    check("coll_dac_en", int'(dac_en), 0);

    // Randomized traffic; only collisions with defined outcomes are generated
    for (int i = 0; i < 3000; i++) begin
      bit rst, wr, tt, lt, st, et, trig;
      int a, dd;
      rst = ($urandom_range(0, 299) == 0);
      wr  = ($urandom_range(0, 4) == 0);
      a   = $urandom_range(0, 7);
      dd  = $urandom_range(0, 255);
      tt  = $urandom_range(0, 1) != 0;
      lt  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 3) == 0);
      et  = ($urandom_range(0, 3) == 0);
      trig = (a == 4) && dd[7];
      if (wr && a <= 4 && !trig) begin
        tt = 1'b0; st = 1'b0; et = 1'b0;
        if (a != 1) lt = 1'b0;
      end
      cycle(rst, wr, a, dd, tt, lt, st, et);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
